irq_dispatch: RTL and testbench

//  Interrupt initiator for the register group's interrupt port. Latches

---
 rtl/irq_dispatch.sv | 174 +++++++++++++++++
 tb/tb_irq_dispatch.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatch.sv
// -----------------------------------------------------------------------------
// irq_dispatch
//
// Interrupt initiator for the register group's interrupt port. Rising edges on
// irq_in are latched into per-line pending bits. When interrupts are globally
// enabled (sys[0]) and some pending line is enabled, the lowest-numbered such
// line is selected and fetch is stalled until the pipeline has drained and a
// valid resume address is available. A one-cycle interrupt_ask then carries the
// vector address and the return address to the register group, which loads
// pc/ipc and clears sys (disabling further interrupts).
//
// Ports
//   clk            clock, all state on posedge
//   all_rst_n      asynchronous active-low reset
//   irq_in         request lines, rising edge = request
//   irq_en         per-line enable mask
//   sys            sys register, bit0 = global interrupt enable
//   pipe_busy      1 while any write-back is still in flight
//   resume_pc      address of the next instruction to execute
//   resume_valid   resume_pc is meaningful this cycle
//   pc_stop_req    stall request for fetch
//   interrupt_ask  one-cycle strobe to the register group
//   interrupt_pc   vector address, valid with interrupt_ask
//   interrupt_ipc  return address, valid with interrupt_ask
//   interrupt      pipeline tag, identical to interrupt_ask
//   interrupt_num  number of the line being taken, valid with interrupt_ask
//   pending        pending latches, for debug/status
// -----------------------------------------------------------------------------
module irq_dispatch #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               all_rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [31:0]        sys,
    input  logic               pipe_busy,
    input  logic [31:0]        resume_pc,
    input  logic               resume_valid,
    output logic               pc_stop_req,
    output logic               interrupt_ask,
    output logic [31:0]        interrupt_pc,
    output logic [31:0]        interrupt_ipc,
    output logic               interrupt,
    output logic [7:0]         interrupt_num,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int IDXW  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    // Stride is a power of two, so the vector offset is a plain shift.
    localparam int SHIFT = $clog2(VEC_STRIDE);

    typedef enum logic [1:0] {
        ST_IDLE,   // waiting for an enabled pending request
        ST_DRAIN,  // fetch stalled, waiting for the pipeline to empty
        ST_ASK,    // one-cycle strobe to the register group
        ST_HOLD    // gap cycle while the sys clear becomes visible
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_hist_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] cand;
    logic               cand_any;
    logic [IDXW-1:0]    cand_idx;
    logic [IDXW-1:0]    sel_q, sel_d;
    logic               take;

    // Only the global enable bit of sys matters here.
    logic unused_sys_hi;
    assign unused_sys_hi = ^sys[31:1];

    // Edges seen this cycle count as requests immediately, so a request can
    // leave IDLE on the same clock edge that latches it.
    assign rise = irq_in & ~irq_hist_q;
    assign cand = (pending_q | rise) & irq_en;

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        cand_any = 1'b0;
        cand_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_any = 1'b1;
                cand_idx = IDXW'(i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        pending_d = pending_q | rise;
        case (state_q)
            ST_IDLE: begin
                if (sys[0] && cand_any) begin
                    state_d = ST_DRAIN;
                    sel_d   = cand_idx;
                end
            end
            ST_DRAIN: begin
                // Abandon without consuming the request; it stays pending.
                // The selected line is never preempted by a later arrival.
                if (!sys[0] || !irq_en[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (!pipe_busy && resume_valid) begin
                    state_d = ST_ASK;
                end
            end
            ST_ASK: begin
                // Consume the taken request unless a fresh edge on the same
                // line arrives in this very cycle.
                pending_d[sel_q] = rise[sel_q];
                state_d          = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign take = (state_q == ST_DRAIN) && (state_d == ST_ASK);

    // State, request latches and edge history
    always_ff @(posedge clk or negedge all_rst_n) begin
        if (!all_rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            pending_q  <= '0;
            // Cleared history makes a line already high at release an edge.
            irq_hist_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state_q    <= state_d;
            sel_q      <= sel_d;
            pending_q  <= pending_d;
            irq_hist_q <= irq_in;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge all_rst_n) begin
        if (!all_rst_n) begin
            pc_stop_req   <= 1'b0;
            interrupt_ask <= 1'b0;
            interrupt_pc  <= '0;
            interrupt_ipc <= '0;
            interrupt_num <= '0;
        end else begin
            pc_stop_req   <= (state_d == ST_DRAIN) || (state_d == ST_ASK);
            interrupt_ask <= (state_d == ST_ASK);
            // Payload only changes on entry to ASK and holds otherwise.
            if (take) begin
                interrupt_pc  <= VEC_BASE + (32'(sel_q) << SHIFT);
                interrupt_ipc <= resume_pc;
                interrupt_num <= 8'(sel_q);
            end
        end
    end

    assign interrupt = interrupt_ask;
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// -----------------------------------------------------------------------------
// tb_irq_dispatch
//
// Self-checking bench for irq_dispatch (default parameters: 8 lines, vectors at
// 0x100 with stride 4). Directed scenarios check exact timing; a randomized
// scenario checks the order and payload of every ask against a request-set
// model: all lines raised in a burst are served in ascending order, enabled
// lines first, masked lines once their enables are turned on, and every ask
// carries the resume_pc offered in the cycle before it.
// -----------------------------------------------------------------------------
module tb_irq_dispatch;

    localparam int HN = 16384;

    logic        clk = 1'b0;
    logic        all_rst_n;
    logic [7:0]  irq_in;
    logic [7:0]  irq_en;
    logic [31:0] sys;
    logic        pipe_busy;
    logic [31:0] resume_pc;
    logic        resume_valid;
    logic        pc_stop_req;
    logic        interrupt_ask;
    logic [31:0] interrupt_pc;
    logic [31:0] interrupt_ipc;
    logic        interrupt;
    logic [7:0]  interrupt_num;
    logic [7:0]  pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [7:0]  num;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic        intr;
        logic        stop;
    } ask_ev_t;

    ask_ev_t     evq[$];
    logic [31:0] rpc_hist   [HN];
    logic        busy_hist  [HN];
    logic        valid_hist [HN];

    irq_dispatch dut (
        .clk           (clk),
        .all_rst_n     (all_rst_n),
        .irq_in        (irq_in),
        .irq_en        (irq_en),
        .sys           (sys),
        .pipe_busy     (pipe_busy),
        .resume_pc     (resume_pc),
        .resume_valid  (resume_valid),
        .pc_stop_req   (pc_stop_req),
        .interrupt_ask (interrupt_ask),
        .interrupt_pc  (interrupt_pc),
        .interrupt_ipc (interrupt_ipc),
        .interrupt     (interrupt),
        .interrupt_num (interrupt_num),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: records the inputs offered this cycle and every ask.
    always @(negedge clk) begin
        ask_ev_t ev;
        rpc_hist[cyc % HN]   = resume_pc;
        busy_hist[cyc % HN]  = pipe_busy;
        valid_hist[cyc % HN] = resume_valid;
        if (interrupt_ask === 1'b1) begin
            ev.cyc  = cyc;
            ev.num  = interrupt_num;
            ev.pc   = interrupt_pc;
            ev.ipc  = interrupt_ipc;
            ev.intr = interrupt;
            ev.stop = pc_stop_req;
            evq.push_back(ev);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] vec_of(input int n);
        return 32'h0000_0100 + 32'(n * 4);
    endfunction

    task automatic test_reset();
        all_rst_n    = 1'b0;
        irq_in       = '0;
        irq_en       = '0;
        sys          = '0;
        pipe_busy    = 1'b0;
        resume_pc    = '0;
        resume_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({pc_stop_req, interrupt_ask, interrupt} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000", {pc_stop_req, interrupt_ask, interrupt});
        end
        checks++;
        if (interrupt_pc !== 32'h0 || interrupt_ipc !== 32'h0) begin
            failures++;
            $display("FAIL reset_vec pc=%h ipc=%h exp=0", interrupt_pc, interrupt_ipc);
        end
        checks++;
        if (interrupt_num !== 8'h0 || pending !== 8'h0) begin
            failures++;
            $display("FAIL reset_num num=%h pending=%h exp=0", interrupt_num, pending);
        end
        all_rst_n = 1'b1;
        tick();
    endtask

    // Single request, drained pipeline: ask exactly two cycles after the edge.
    task automatic test_basic();
        sys          = 32'h1;
        irq_en       = 8'hFF;
        resume_valid = 1'b1;
        resume_pc    = 32'h1234;
        irq_in       = 8'h08;
        tick();
        checks++;
        if (pc_stop_req !== 1'b1 || interrupt_ask !== 1'b0) begin
            failures++;
            $display("FAIL basic_drain stop=%b ask=%b exp stop=1 ask=0", pc_stop_req, interrupt_ask);
        end
        tick();
        checks++;
        if (interrupt_ask !== 1'b1 || interrupt !== 1'b1 || pc_stop_req !== 1'b1) begin
            failures++;
            $display("FAIL basic_ask ask=%b intr=%b stop=%b exp 1 1 1", interrupt_ask, interrupt, pc_stop_req);
        end
        checks++;
        if (interrupt_pc !== 32'h10C || interrupt_ipc !== 32'h1234 || interrupt_num !== 8'd3) begin
            failures++;
            $display("FAIL basic_payload pc=%h ipc=%h num=%0d exp pc=10c ipc=1234 num=3",
                     interrupt_pc, interrupt_ipc, interrupt_num);
        end
        tick();
        checks++;
        if (interrupt_ask !== 1'b0 || pc_stop_req !== 1'b0 || pending !== 8'h00) begin
            failures++;
            $display("FAIL basic_hold ask=%b stop=%b pending=%h exp 0 0 00", interrupt_ask, pc_stop_req, pending);
        end
        checks++;
        if (interrupt_pc !== 32'h10C || interrupt_num !== 8'd3) begin
            failures++;
            $display("FAIL basic_payload_hold pc=%h num=%0d exp pc=10c num=3", interrupt_pc, interrupt_num);
        end
        irq_in = '0;
        repeat (4) tick();
    endtask

    // Simultaneous edges: lower line first, higher line after the minimum gap.
    task automatic test_same_cycle();
        evq.delete();
        irq_in = 8'h24;
        tick();
        irq_in = '0;
        repeat (20) tick();
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL same_cycle_count got=%0d exp=2", evq.size());
        end else begin
            checks++;
            if (evq[0].num !== 8'd2 || evq[0].pc !== 32'h108) begin
                failures++;
                $display("FAIL same_cycle_first num=%0d pc=%h exp num=2 pc=108", evq[0].num, evq[0].pc);
            end
            checks++;
            if (evq[1].num !== 8'd5 || evq[1].pc !== 32'h114) begin
                failures++;
                $display("FAIL same_cycle_second num=%0d pc=%h exp num=5 pc=114", evq[1].num, evq[1].pc);
            end
            checks++;
            if (evq[1].cyc - evq[0].cyc < 3) begin
                failures++;
                $display("FAIL same_cycle_gap got=%0d exp>=3", evq[1].cyc - evq[0].cyc);
            end
        end
    endtask

    // Busy pipeline holds the stall; ask follows the first idle cycle.
    task automatic test_busy();
        logic [31:0] exp_ipc;
        int          bad;
        bad       = 0;
        exp_ipc   = 32'hCAFE_0010;
        pipe_busy = 1'b1;
        irq_in    = 8'h10;
        for (int i = 1; i <= 10; i++) begin
            tick();
            irq_in    = '0;
            resume_pc = $urandom;
            if (pc_stop_req !== 1'b1 || interrupt_ask !== 1'b0) bad++;
            if (i == 10) begin
                pipe_busy = 1'b0;
                resume_pc = exp_ipc;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_stall bad_cycles=%0d exp=0", bad);
        end
        tick();
        checks++;
        if (interrupt_ask !== 1'b1 || interrupt_ipc !== exp_ipc || interrupt_num !== 8'd4
            || interrupt_pc !== 32'h110) begin
            failures++;
            $display("FAIL busy_ask ask=%b ipc=%h num=%0d pc=%h exp ask=1 ipc=%h num=4 pc=110",
                     interrupt_ask, interrupt_ipc, interrupt_num, interrupt_pc, exp_ipc);
        end
        repeat (4) tick();
    endtask

    // Global disable in DRAIN abandons the attempt but keeps the request.
    task automatic test_sys_drop();
        evq.delete();
        pipe_busy = 1'b1;
        irq_in    = 8'h40;
        tick();
        irq_in = '0;
        checks++;
        if (pc_stop_req !== 1'b1) begin
            failures++;
            $display("FAIL sys_drop_drain stop=%b exp=1", pc_stop_req);
        end
        sys = 32'h0;
        tick();
        checks++;
        if (pc_stop_req !== 1'b0) begin
            failures++;
            $display("FAIL sys_drop_release stop=%b exp=0", pc_stop_req);
        end
        pipe_busy = 1'b0;
        repeat (5) tick();
        checks++;
        if (evq.size() != 0 || pending !== 8'h40) begin
            failures++;
            $display("FAIL sys_drop_kept asks=%0d pending=%h exp asks=0 pending=40", evq.size(), pending);
        end
        sys = 32'h1;
        repeat (6) tick();
        checks++;
        if (evq.size() != 1 || (evq.size() == 1 && evq[0].num !== 8'd6)) begin
            failures++;
            $display("FAIL sys_drop_resume asks=%0d exp one ask on line 6", evq.size());
        end
    endtask

    // Reset in DRAIN: outputs fall asynchronously, request is forgotten.
    task automatic test_reset_mid();
        evq.delete();
        pipe_busy = 1'b1;
        irq_in    = 8'h01;
        tick();
        irq_in = '0;
        checks++;
        if (pc_stop_req !== 1'b1 || pending !== 8'h01) begin
            failures++;
            $display("FAIL reset_mid_pre stop=%b pending=%h exp stop=1 pending=01", pc_stop_req, pending);
        end
        #3;
        all_rst_n = 1'b0;
        #1;
        checks++;
        if (pc_stop_req !== 1'b0 || interrupt_ask !== 1'b0 || pending !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_async stop=%b ask=%b pending=%h exp all 0",
                     pc_stop_req, interrupt_ask, pending);
        end
        tick();
        all_rst_n = 1'b1;
        pipe_busy = 1'b0;
        repeat (10) tick();
        checks++;
        if (evq.size() != 0 || pending !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_after asks=%0d pending=%h exp asks=0 pending=00", evq.size(), pending);
        end
    endtask

    // A level held high is still only one request.
    task automatic test_level();
        evq.delete();
        irq_in = 8'h02;
        repeat (20) tick();
        irq_in = '0;
        repeat (5) tick();
        checks++;
        if (evq.size() != 1 || (evq.size() == 1 && evq[0].num !== 8'd1)) begin
            failures++;
            $display("FAIL level_once asks=%0d exp one ask on line 1", evq.size());
        end
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            pipe_busy    = 1'($urandom_range(0, 1));
            resume_valid = ($urandom_range(0, 3) != 0);
            resume_pc    = $urandom;
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] set;
        logic [7:0] en;
        int         exp_list[$];
        int         k;
        for (int b = 0; b < 20; b++) begin
            evq.delete();
            exp_list.delete();
            set    = 8'($urandom_range(1, 255));
            en     = 8'($urandom_range(0, 255));
            irq_en = en;
            sys    = $urandom | 32'h1;
            irq_in = set;
            tick();
            irq_in = '0;
            checks++;
            if (pending !== set) begin
                failures++;
                $display("FAIL rand_latch burst=%0d pending=%h exp=%h", b, pending, set);
            end
            run_random(150);
            checks++;
            if (pending !== (set & ~en)) begin
                failures++;
                $display("FAIL rand_masked burst=%0d pending=%h exp=%h", b, pending, set & ~en);
            end
            irq_en = 8'hFF;
            run_random(150);
            checks++;
            if (pending !== 8'h00) begin
                failures++;
                $display("FAIL rand_drained burst=%0d pending=%h exp=00", b, pending);
            end
            for (int i = 0; i < 8; i++) if (set[i] && en[i]) exp_list.push_back(i);
            for (int i = 0; i < 8; i++) if (set[i] && !en[i]) exp_list.push_back(i);
            checks++;
            if (evq.size() != exp_list.size()) begin
                failures++;
                $display("FAIL rand_count burst=%0d asks=%0d exp=%0d", b, evq.size(), exp_list.size());
            end
            k = (evq.size() < exp_list.size()) ? evq.size() : exp_list.size();
            for (int j = 0; j < k; j++) begin
                int c;
                c = (evq[j].cyc - 1) % HN;
                checks++;
                if (evq[j].num !== 8'(exp_list[j]) || evq[j].pc !== vec_of(exp_list[j])) begin
                    failures++;
                    $display("FAIL rand_order burst=%0d ask=%0d num=%0d pc=%h exp num=%0d pc=%h",
                             b, j, evq[j].num, evq[j].pc, exp_list[j], vec_of(exp_list[j]));
                end
                checks++;
                if (evq[j].ipc !== rpc_hist[c] || busy_hist[c] !== 1'b0 || valid_hist[c] !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_ipc burst=%0d ask=%0d ipc=%h exp=%h prev busy=%b valid=%b",
                             b, j, evq[j].ipc, rpc_hist[c], busy_hist[c], valid_hist[c]);
                end
                checks++;
                if (evq[j].intr !== 1'b1 || evq[j].stop !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_flags burst=%0d ask=%0d intr=%b stop=%b exp 1 1",
                             b, j, evq[j].intr, evq[j].stop);
                end
                if (j > 0) begin
                    checks++;
                    if (evq[j].cyc - evq[j-1].cyc < 3) begin
                        failures++;
                        $display("FAIL rand_gap burst=%0d ask=%0d gap=%0d exp>=3",
                                 b, j, evq[j].cyc - evq[j-1].cyc);
                    end
                end
            end
            pipe_busy    = 1'b0;
            resume_valid = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_busy();
        test_sys_drop();
        test_reset_mid();
        sys          = 32'h1;
        irq_en       = 8'hFF;
        resume_valid = 1'b1;
        test_level();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
